attack_map_arbiter: RTL
=======================

Name: attack_map_arbiter

Overview:
- Shares one attack-map evaluator among NUM_REQ requesters (move generator, castling check, legality filter, ...).
- The evaluator is a bank of 64 per-square attack detectors plus a collector.
- The arbiter selects a requester round-robin, captures its board and attacker side, and launches one evaluation.
- It then waits for the 64-bit attacked-square map, with a timeout, and returns the map to the granted requester.

Parameters:
- PIECE_WIDTH, 4, bits per square code.
- BOARD_WIDTH, 256, PIECE_WIDTH*64; square s occupies bits [s*PIECE_WIDTH +: PIECE_WIDTH], with s = rank*8+file.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 31, maximum cycles in WAIT before abort (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until accepted.
- req_board  in  NUM_REQ*BOARD_WIDTH  requester i board at [i*BOARD_WIDTH +: BOARD_WIDTH].
- req_attacker  in  NUM_REQ  side whose attacks are mapped, per requester: 0 = white attack, 1 = black attack.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- eval_board  out  BOARD_WIDTH  registered board driven to evaluator.
- eval_attacker  out  1  registered attacker side.
- eval_board_valid  out  1  single-cycle launch pulse.
- eval_map  in  64  bit s = square s attacked.
- eval_map_valid  in  1  evaluator result strobe.
- rsp_valid  out  NUM_REQ  one-hot single-cycle response to the granted requester.
- rsp_map  out  64  registered result map.
- rsp_timeout  out  1  qualifies rsp_valid: evaluator did not answer.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset (reset = 0, asynchronous), all outputs 0:
- req_ready, eval_board, eval_attacker, eval_board_valid, rsp_valid, rsp_map, rsp_timeout, busy = 0.
- state = IDLE, rr_ptr = 0, timeout counter = 0.

IDLE:
- If any req_valid bit is set, grant = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
- Same cycle: register the granted board into eval_board and the granted attacker bit into eval_attacker.
- Next cycle: req_ready[grant] = 1 for exactly one cycle; go to LAUNCH.
- No request: stay in IDLE; outputs hold, except pulse outputs, which are 0.

LAUNCH:
- eval_board_valid = 1 for one cycle; clear the timeout counter; go to WAIT.
- eval_board and eval_attacker stay stable from LAUNCH until the next grant.

WAIT:
- Counter increments each cycle.
- eval_map_valid = 1: capture eval_map into rsp_map, rsp_timeout = 0, go to RESPOND.
- Else if counter == TIMEOUT: rsp_map = 0, rsp_timeout = 1, go to RESPOND.
- If eval_map_valid arrives in the cycle the counter reaches TIMEOUT, the valid wins (no timeout).

RESPOND:
- rsp_valid[grant] = 1 for one cycle.
- rr_ptr = (grant+1) mod NUM_REQ.
- Go to IDLE.
- rsp_map and rsp_timeout hold until the next capture.

Latency and throughput:
- Request seen in IDLE → req_ready: 1 cycle.
- Request seen in IDLE → eval_board_valid: 2 cycles.
- eval_map_valid → rsp_valid: 1 cycle.
- Minimum turnaround, request to next grant decision: evaluator latency + 4 cycles.
- One evaluation in flight at a time; no pipelining.

Edge and error cases:
- eval_map_valid arriving in IDLE, LAUNCH or RESPOND is a stray strobe: ignored, no state change.
- A requester dropping req_valid before req_ready is legal. Arbitration re-evaluates every IDLE cycle, and the grant is fixed only at the IDLE→LAUNCH transition.
- Simultaneous requests: only one grant per arbitration. The others stay pending and are served in subsequent rounds in rotating order, so no starvation.
- The request bit of a requester whose turn is in RESPOND is not sampled until IDLE.
- reset asserted mid-WAIT: immediate return to IDLE with all outputs 0, and no response to the aborted requester. A late eval_map_valid after reset release is ignored as stray.
- Timeout counter width: clog2(TIMEOUT+1); no wrap possible.

Test Plan:
- Single request, NUM_REQ = 4, requester 2, attacker = 0; evaluator answers 3 cycles after launch with map 64'h0000_0000_00FF_0000.
  → req_ready = 4'b0100 one cycle; eval_board_valid one pulse; rsp_valid = 4'b0100 with rsp_map = 64'h0000_0000_00FF_0000, rsp_timeout = 0.
- All four req_valid held high for 4 rounds, evaluator fixed latency 2.
  → grants in order 0,1,2,3; each rsp_valid one-hot matches its grant; eval_board equals that requester's board each time.
- rr_ptr = 3, requests from 1 and 3.
  → 3 is granted first, then 1 (wrap-around).
- Evaluator silent, TIMEOUT = 31.
  → rsp_valid exactly 32 cycles after eval_board_valid, with rsp_timeout = 1 and rsp_map = 0; next request is served normally.
- eval_map_valid coincides with the counter reaching TIMEOUT.
  → rsp_timeout = 0 and the captured map is returned. A stray eval_map_valid in IDLE causes no rsp_valid.
- reset driven low 2 cycles into WAIT.
  → busy = 0 and all outputs 0 asynchronously. After release, a late eval_map_valid produces no rsp_valid, and a new request from requester 0 completes normally.

Source files
------------

// File: rtl/attack_map_arbiter.sv
// Round-robin arbiter that shares one attack-map evaluator among NUM_REQ requesters.
// Each grant launches one evaluation and returns the map, or a timeout response, to the winner.
`timescale 1ns/1ps

module attack_map_arbiter #(
   parameter int PIECE_WIDTH = 4,
   parameter int BOARD_WIDTH = PIECE_WIDTH * 64,
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT     = 31
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*BOARD_WIDTH-1:0] req_board,
   input  logic [NUM_REQ-1:0]             req_attacker,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [BOARD_WIDTH-1:0]         eval_board,
   output logic                           eval_attacker,
   output logic                           eval_board_valid,
   input  logic [63:0]                    eval_map,
   input  logic                           eval_map_valid,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [63:0]                    rsp_map,
   output logic                           rsp_timeout,
   output logic                           busy
);

   localparam int GRANT_W = $clog2(NUM_REQ);
   localparam int CNT_W   = $clog2(TIMEOUT + 1);

   localparam logic [GRANT_W:0]   NUM_REQ_EXT = (GRANT_W + 1)'(NUM_REQ);
   localparam logic [GRANT_W-1:0] LAST_REQ    = GRANT_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]   CNT_LIMIT   = CNT_W'(TIMEOUT);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LAUNCH  = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RESPOND = 2'd3;

   logic [1:0]             r_state;
   logic [GRANT_W-1:0]     r_rr_ptr;
   logic [GRANT_W-1:0]     r_grant;
   logic [CNT_W-1:0]       r_cnt;
   logic [NUM_REQ-1:0]     r_req_ready;
   logic [BOARD_WIDTH-1:0] r_eval_board;
   logic                   r_eval_attacker;
   logic                   r_eval_board_valid;
   logic [NUM_REQ-1:0]     r_rsp_valid;
   logic [63:0]            r_rsp_map;
   logic                   r_rsp_timeout;

   logic [BOARD_WIDTH-1:0] w_boards [NUM_REQ];
   logic [NUM_REQ-1:0]     w_rot;
   logic [GRANT_W-1:0]     w_off;
   logic [GRANT_W:0]       w_sum;
   logic [GRANT_W-1:0]     w_grant;
   logic                   w_any;
   logic [GRANT_W-1:0]     w_next_ptr;
   logic [NUM_REQ-1:0]     w_grant_oh;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_board
      assign w_boards[i] = req_board[i*BOARD_WIDTH +: BOARD_WIDTH];
   end

   // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit is the winner.
   assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
   assign w_any = |req_valid;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = GRANT_W'(k);
      end
   end

   assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_grant    = (w_sum >= NUM_REQ_EXT) ? GRANT_W'(w_sum - NUM_REQ_EXT) : w_sum[GRANT_W-1:0];
   assign w_next_ptr = (r_grant == LAST_REQ) ? '0 : r_grant + GRANT_W'(1);
   assign w_grant_oh = NUM_REQ'(1) << r_grant;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state            <= S_IDLE;
         r_rr_ptr           <= '0;
         r_grant            <= '0;
         r_cnt              <= '0;
         r_req_ready        <= '0;
         r_eval_board       <= '0;
         r_eval_attacker    <= 1'b0;
         r_eval_board_valid <= 1'b0;
         r_rsp_valid        <= '0;
         r_rsp_map          <= '0;
         r_rsp_timeout      <= 1'b0;
      end else begin
         r_req_ready        <= '0;
         r_eval_board_valid <= 1'b0;
         r_rsp_valid        <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant         <= w_grant;
                  r_eval_board    <= w_boards[w_grant];
                  r_eval_attacker <= req_attacker[w_grant];
                  r_req_ready     <= NUM_REQ'(1) << w_grant;
                  r_state         <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_eval_board_valid <= 1'b1;
               r_cnt              <= '0;
               r_state            <= S_WAIT;
            end
            S_WAIT: begin
               // A result in the final cycle still beats the timeout.
               if (eval_map_valid) begin
                  r_rsp_map     <= eval_map;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_valid   <= w_grant_oh;
                  r_state       <= S_RESPOND;
               end else if (r_cnt == CNT_LIMIT) begin
                  r_rsp_map     <= '0;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_valid   <= w_grant_oh;
                  r_state       <= S_RESPOND;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RESPOND: begin
               r_rr_ptr <= w_next_ptr;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready        = r_req_ready;
   assign eval_board       = r_eval_board;
   assign eval_attacker    = r_eval_attacker;
   assign eval_board_valid = r_eval_board_valid;
   assign rsp_valid        = r_rsp_valid;
   assign rsp_map          = r_rsp_map;
   assign rsp_timeout      = r_rsp_timeout;
   assign busy             = (r_state != S_IDLE);

endmodule
